// File: rtl/branch_resolve_if.sv
// branch_resolve_if: ID-stage branch handshake between the decode/forwarding side and branch_resolve.
//  master: drives br_valid_d, br_type_d, equal_d, ltz_d, opnd_ready_d, pc_plus4_d, imm_d, instr_idx_d
//          and observes stall_d, redirect_valid, redirect_pc, flush_f
//  slave : the branch resolver (mirror directions)
interface branch_resolve_if;
    logic        br_valid_d;
    logic [2:0]  br_type_d;
    logic        equal_d;
    logic        ltz_d;
    logic        opnd_ready_d;
    logic [31:0] pc_plus4_d;
    logic [15:0] imm_d;
    logic [25:0] instr_idx_d;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_f;
    modport master (
        output br_valid_d, br_type_d, equal_d, ltz_d, opnd_ready_d, pc_plus4_d, imm_d, instr_idx_d,
        input  stall_d, redirect_valid, redirect_pc, flush_f
    );
    modport slave (
        input  br_valid_d, br_type_d, equal_d, ltz_d, opnd_ready_d, pc_plus4_d, imm_d, instr_idx_d,
        output stall_d, redirect_valid, redirect_pc, flush_f
    );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch/jump resolver driving PC redirect, IF flush and operand-wait stall.
//  clk          rising-edge clock
//  reset        synchronous active-high reset
//  br           branch_resolve_if.slave (ID inputs, stall_d, redirect_valid/redirect_pc, flush_f)
//  err_timeout  sticky: operand wait reached WAIT_MAX cycles
//  taken_cnt    saturating count of taken resolves (0 unless BRANCH_STATS_EN)
//  resolved_cnt saturating count of all resolves  (0 unless BRANCH_STATS_EN)
//  Optional feature macro: BRANCH_STATS_EN builds the statistics counters.
module branch_resolve #(
    parameter int WAIT_MAX = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  br,
    output logic             err_timeout,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] resolved_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT, REDIRECT} state_t;
    localparam logic [3:0] WM = 4'(WAIT_MAX);
    state_t      state;
    logic [3:0]  wait_cnt;
    logic        taken;
    logic        resolve;
    logic [31:0] target;
    always_comb begin
        taken = (br.br_type_d == 3'd0) ?  br.equal_d :
                (br.br_type_d == 3'd1) ? !br.equal_d :
                (br.br_type_d == 3'd2) ?  br.ltz_d   :
                (br.br_type_d == 3'd3) ? !br.ltz_d   :
                (br.br_type_d == 3'd4);
        target = (br.br_type_d == 3'd4) ? {br.pc_plus4_d[31:28], br.instr_idx_d, 2'b00}
                                        : br.pc_plus4_d + {{14{br.imm_d[15]}}, br.imm_d, 2'b00};
        // The slot behind a taken branch is being flushed, so nothing resolves in REDIRECT.
        resolve = br.br_valid_d & br.opnd_ready_d & (state != REDIRECT);
    end
    assign br.stall_d = !reset & br.br_valid_d & !br.opnd_ready_d & (state != REDIRECT);
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            err_timeout       <= 1'b0;
            br.redirect_valid <= 1'b0;
            br.flush_f        <= 1'b0;
            br.redirect_pc    <= '0;
        end else begin
            br.redirect_valid <= resolve & taken;
            br.flush_f        <= resolve & taken;
            if (resolve & taken)
                br.redirect_pc <= target;
            if (resolve) begin
                state    <= taken ? REDIRECT : IDLE;
                wait_cnt <= '0;
            end else if (state == REDIRECT) begin
                state <= IDLE;
            end else if (br.br_valid_d) begin
                state    <= WAIT;
                wait_cnt <= (wait_cnt < WM) ? wait_cnt + 4'd1 : wait_cnt;
                if (state == WAIT && wait_cnt + 4'd1 >= WM)
                    err_timeout <= 1'b1;
            end else begin
                state    <= IDLE;
                wait_cnt <= '0;
            end
        end
    end
`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt    <= '0;
            resolved_cnt <= '0;
        end else begin
            if (resolve && !(&resolved_cnt))
                resolved_cnt <= resolved_cnt + 1'b1;
            if (resolve && taken && !(&taken_cnt))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end
`else
    assign taken_cnt    = '0;
    assign resolved_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed plus randomized checks of branch_resolve against a cycle-level reference model.
module tb_branch_resolve;
    localparam int WAIT_MAX = 3;
    localparam int CNT_W    = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err_timeout;
    logic [CNT_W-1:0] taken_cnt, resolved_cnt;
    int checks = 0;
    int failures = 0;
    branch_resolve_if bif ();
    branch_resolve #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .br(bif.slave),
        .err_timeout(err_timeout), .taken_cnt(taken_cnt), .resolved_cnt(resolved_cnt)
    );
    always #5 clk = ~clk;
    bit          m_redirect;
    int          m_waits;
    bit          m_err;
    bit          m_rv;
    logic [31:0] m_pc;
    int          m_taken_n;
    int          m_resolved_n;
    bit          last_stall;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit is_taken(input logic [2:0] ty, input bit eq, input bit lz);
        case (ty)
            3'd0: return eq;
            3'd1: return !eq;
            3'd2: return lz;
            3'd3: return !lz;
            3'd4: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    function automatic logic [31:0] target_of(input logic [2:0] ty, input logic [31:0] pc,
                                             input logic [15:0] im, input logic [25:0] ix);
        logic [31:0] off;
        off = {{16{im[15]}}, im};
        if (ty == 3'd4) return (pc & 32'hF000_0000) | ({6'd0, ix} * 32'd4);
        return pc + off * 32'd4;
    endfunction
    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef BRANCH_STATS_EN
        return (n > (1 << CNT_W) - 1) ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(n);
`else
        return (n >= 0) ? '0 : '1;
`endif
    endfunction
    task automatic step(input bit r, input bit v, input logic [2:0] ty, input bit eq, input bit lz,
                        input bit rd, input logic [31:0] pc, input logic [15:0] im, input logic [25:0] ix);
        bit t;
        reset = r;
        bif.br_valid_d = v; bif.br_type_d = ty; bif.equal_d = eq; bif.ltz_d = lz;
        bif.opnd_ready_d = rd; bif.pc_plus4_d = pc; bif.imm_d = im; bif.instr_idx_d = ix;
        #1;
        last_stall = bif.stall_d;
        chk("stall_d", 64'(bif.stall_d), 64'(!r && v && !rd && !m_redirect));
        if (r) begin
            m_redirect = 0; m_waits = 0; m_err = 0; m_rv = 0; m_pc = '0;
            m_taken_n = 0; m_resolved_n = 0;
        end else if (m_redirect) begin
            m_redirect = 0; m_rv = 0; m_waits = 0;
        end else if (v && rd) begin
            t = is_taken(ty, eq, lz);
            m_resolved_n++;
            m_waits = 0;
            m_rv = t;
            m_redirect = t;
            if (t) begin
                m_taken_n++;
                m_pc = target_of(ty, pc, im, ix);
            end
        end else if (v) begin
            if (m_waits < WAIT_MAX) m_waits++;
            if (m_waits >= WAIT_MAX) m_err = 1;
            m_rv = 0;
        end else begin
            m_waits = 0; m_rv = 0;
        end
        @(posedge clk);
        #1;
        chk("redirect_valid", 64'(bif.redirect_valid), 64'(m_rv));
        chk("flush_f", 64'(bif.flush_f), 64'(m_rv));
        chk("redirect_pc", 64'(bif.redirect_pc), 64'(m_pc));
        chk("err_timeout", 64'(err_timeout), 64'(m_err));
        chk("taken_cnt", 64'(taken_cnt), 64'(exp_cnt(m_taken_n)));
        chk("resolved_cnt", 64'(resolved_cnt), 64'(exp_cnt(m_resolved_n)));
    endtask
    task automatic idle();
        step(0, 0, 3'd0, 0, 0, 1, 32'd0, 16'd0, 26'd0);
    endtask
    task automatic bra(input logic [2:0] ty, input bit eq, input bit lz, input bit rd,
                       input logic [31:0] pc, input logic [15:0] im, input logic [25:0] ix);
        step(0, 1, ty, eq, lz, rd, pc, im, ix);
    endtask
    initial begin
        bif.br_valid_d = 0; bif.br_type_d = 0; bif.equal_d = 0; bif.ltz_d = 0;
        bif.opnd_ready_d = 0; bif.pc_plus4_d = 0; bif.imm_d = 0; bif.instr_idx_d = 0;
        step(1, 0, 3'd0, 0, 0, 0, 32'd0, 16'd0, 26'd0);
        step(1, 1, 3'd0, 0, 0, 0, 32'd0, 16'd0, 26'd0);
        chk("reset_stall", 64'(last_stall), 64'd0);
        chk("reset_rv", 64'(bif.redirect_valid), 64'd0);
        bra(3'd0, 1, 0, 1, 32'h0040_0010, 16'h0004, 26'd0);
        chk("beq_rv", 64'(bif.redirect_valid), 64'd1);
        chk("beq_pc", 64'(bif.redirect_pc), 64'h0040_0020);
        idle();
        chk("beq_pulse_end", 64'(bif.redirect_valid), 64'd0);
        bra(3'd1, 1, 0, 1, 32'h0000_1000, 16'h0010, 26'd0);
        chk("bne_stall", 64'(last_stall), 64'd0);
        chk("bne_no_redirect", 64'(bif.redirect_valid), 64'd0);
        bra(3'd0, 1, 0, 1, 32'h0000_1004, 16'h0008, 26'd0);
        chk("b2b_beq_pc", 64'(bif.redirect_pc), 64'h0000_1024);
        idle();
        bra(3'd2, 0, 1, 1, 32'h0000_0004, 16'hFFFF, 26'd0);
        chk("bltz_pc", 64'(bif.redirect_pc), 64'h0000_0000);
        idle();
        bra(3'd2, 0, 1, 1, 32'h0000_0000, 16'hFFFF, 26'd0);
        chk("bltz_wrap", 64'(bif.redirect_pc), 64'hFFFF_FFFC);
        idle();
        bra(3'd4, 0, 0, 1, 32'h9000_0000, 16'h0000, 26'h000_0100);
        chk("j_pc", 64'(bif.redirect_pc), 64'h9000_0400);
        bra(3'd0, 1, 0, 0, 32'h0000_2000, 16'h0001, 26'd0);
        chk("redirect_slot_stall", 64'(last_stall), 64'd0);
        chk("redirect_slot_ignored", 64'(bif.redirect_valid), 64'd0);
        bra(3'd3, 0, 0, 0, 32'h0000_3000, 16'h0002, 26'd0);
        chk("bgez_wait1", 64'(last_stall), 64'd1);
        bra(3'd3, 0, 0, 0, 32'h0000_3000, 16'h0002, 26'd0);
        chk("bgez_wait2", 64'(last_stall), 64'd1);
        bra(3'd3, 0, 0, 1, 32'h0000_3000, 16'h0002, 26'd0);
        chk("bgez_resolve_stall", 64'(last_stall), 64'd0);
        chk("bgez_pc", 64'(bif.redirect_pc), 64'h0000_3008);
        chk("bgez_no_err", 64'(err_timeout), 64'd0);
        idle();
        for (int i = 0; i < 4; i++) bra(3'd3, 0, 0, 0, 32'h0000_4000, 16'h0002, 26'd0);
        chk("timeout", 64'(err_timeout), 64'd1);
        step(1, 1, 3'd3, 0, 0, 0, 32'h0000_4000, 16'h0002, 26'd0);
        chk("reset_wait_stall", 64'(last_stall), 64'd0);
        chk("reset_wait_err", 64'(err_timeout), 64'd0);
        bra(3'd0, 1, 0, 1, 32'h100, 16'h1, 26'd0); idle();
        bra(3'd1, 1, 0, 1, 32'h100, 16'h1, 26'd0);
        bra(3'd4, 0, 0, 1, 32'h100, 16'h1, 26'h40); idle();
        bra(3'd7, 1, 1, 1, 32'h100, 16'h1, 26'd0);
        bra(3'd2, 0, 1, 1, 32'h100, 16'h1, 26'd0); idle();
`ifdef BRANCH_STATS_EN
        chk("stats_taken", 64'(taken_cnt), 64'd3);
        chk("stats_resolved", 64'(resolved_cnt), 64'd5);
`else
        chk("stats_taken_off", 64'(taken_cnt), 64'd0);
        chk("stats_resolved_off", 64'(resolved_cnt), 64'd0);
`endif
        for (int i = 0; i < 3000; i++)
            step(($urandom % 100) == 0, ($urandom % 4) != 0, 3'($urandom % 8), 1'($urandom % 2),
                 1'($urandom % 2), ($urandom % 3) != 0, $urandom, 16'($urandom), 26'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
